uart_ttl_recv: RTL
==================

# uart_ttl_recv

Serial receiver for the UART TTL link: deserialises 8N1 frames (8E1 when parity is compiled in) from `serial_recv` into bytes, LSB first. Uses a 16× oversample tick from the shared baud generator and samples each bit at mid-bit. It is the receive counterpart of `uart_ttl_send` and sits between the pad and the byte consumer, which must take each byte on the single-cycle `recv_valid` pulse.

## Interface
Parameters:
- `OVERSAMPLE`, 16: ticks per bit; must be even, ≥ 8.
- `DATA_BITS`, 8: payload bits per frame.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `serial_recv`  in  1  asynchronous line input; idles high.
- `baud_x16_sign`  in  1  one-`clk` pulse, `OVERSAMPLE` pulses per bit time.
- `recv_data`  out  8  last good byte; holds until the next good frame.
- `recv_valid`  out  1  one-cycle pulse: `recv_data` is updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 without the macro.

## Operation
- `serial_recv` passes through a 2-flop synchroniser with reset value 1. All logic uses the synchronised line `rx_s`.
- `tick_cnt` is 4 bits (log2 `OVERSAMPLE`). It advances only on `baud_x16_sign`.
- `bit_cnt` is 3 bits.
- FSM states:
  - IDLE: when `rx_s`==0, clear `tick_cnt` and go to START.
  - START: on the tick where `tick_cnt`==`OVERSAMPLE/2-1`, check `rx_s`.
    - If 0: clear `tick_cnt` and `bit_cnt`, go to DATA.
    - If 1: glitch; go to IDLE with no output.
  - DATA: on the tick where `tick_cnt`==`OVERSAMPLE-1`, shift `rx_s` into bit 7 of the shift register (right shift, LSB first) and increment `bit_cnt`.
    - After the 8th bit, go to PARITY if enabled, otherwise STOP.
  - PARITY: same sampling rule as DATA; compare the sampled bit with the XOR of the data bits (even parity). Go to STOP.
  - STOP: same sampling rule.
    - If `rx_s`==1 and parity is OK: load `recv_data` and pulse `recv_valid`; go to IDLE.
    - If `rx_s`==1 and parity is bad: pulse `parity_err` and leave `recv_data` unchanged; go to IDLE.
    - If `rx_s`==0: pulse `frame_err` and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. This blocks retriggering during a break.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge is caught with no lost frame.
- `baud_x16_sign` absent: the FSM freezes in its current state with no timeout.

## Timing
- Reset (async assert, sync deassert handled upstream) forces:
  - state IDLE, counters 0, shift register 0;
  - `recv_data`=0, `recv_valid`=0, `frame_err`=0, `parity_err`=0;
  - synchroniser flops = 1.
- Reset asserted mid-frame: the partial byte is discarded. After release, the receiver waits for a fresh falling edge.
- Line-to-FSM latency is 2 `clk` (synchroniser).
- The start edge is detected with up to 1 tick of uncertainty. Sample points therefore land within ±1/16 bit of the bit centre.
- `recv_valid`, `frame_err` and `parity_err` are registered:
  - each asserts in the `clk` after the stop-bit sampling tick;
  - each is high for exactly 1 `clk`;
  - at most one of them fires per frame.
- `recv_data` changes only in the same cycle that `recv_valid` rises.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state exists; frames are 11 bits (start, 8 data, even parity, stop);
  - `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - PARITY state is compiled out; frames are 10 bits (8N1);
  - `parity_err` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - constants `UART_OVERSAMPLE`=16, `UART_DATA_BITS`=8, `UART_LINE_IDLE`=1'b1.
- One sub-module, `uart_sync2`: 2-flop synchroniser with a reset-value parameter. It is reused for other pad inputs.

## Test plan
The bench drives `baud_x16_sign` every 4 `clk` (1 bit = 64 `clk`).
- Frame 0x55, 8N1 → one `recv_valid` pulse, `recv_data`=0x55, both error flags stay 0.
- Bytes 0xA3 then 0x0F sent back-to-back with no idle gap → two `recv_valid` pulses, values 0xA3 then 0x0F in order.
- 20-`clk` low glitch on an idle line → no output pulses; FSM returns to IDLE.
- Frame 0xFF with stop bit forced 0, line then held low for 3 bit times → one `frame_err` pulse, `recv_data` unchanged, no retrigger until the line returns high.
- With `UART_RX_PARITY_EN`: frame 0x07 with parity bit 0 (wrong) → `parity_err` pulse, no `recv_valid`. Frame 0x07 with parity bit 1 → `recv_valid`, `recv_data`=0x07.
- `rst_n` pulled low after 4 data bits of frame 0xC3, then released; frame 0x3C sent → only 0x3C is reported, and all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and link constants.
// Used by uart_ttl_recv and its synchroniser.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int   UART_OVERSAMPLE = 16;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
// RST_VAL sets the level both flops take during reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_ttl_recv.sv
// UART TTL receiver: 16x oversampled, mid-bit sampling, 8N1 frames.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err.
module uart_ttl_recv
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_recv,
  input  logic                 baud_x16_sign,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 recv_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp;

  uart_sync2 #(
    .RST_VAL(UART_LINE_IDLE)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (serial_recv),
    .q    (rx_s)
  );

  assign samp = baud_x16_sign && (tick_cnt == T_END);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      recv_data  <= '0;
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (baud_x16_sign && state != IDLE && state != WAIT_IDLE)
        tick_cnt <= samp ? '0 : tick_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_x16_sign && tick_cnt == T_MID) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (samp) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == B_END) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (samp) begin
            par_bad <= rx_s ^ (^shreg);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (samp) begin
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                recv_data  <= shreg;
                recv_valid <= 1'b1;
              end
`else
              recv_data  <= shreg;
              recv_valid <= 1'b1;
`endif
              state <= IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
